// File: rtl/mms_pkg.sv
// Shared types and the max/min tie-break rule for the serial and combinational selectors.
package mms_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Wide enough for any operand width in use; callers zero-extend before calling.
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] operand_t;

  // Max mode keeps the earlier operand on a tie, min mode takes the later one.
  function automatic logic better(input logic mode, input operand_t cand, input operand_t best);
    if (mode == MODE_MAX) return best < cand;
    else return !(cand > best);
  endfunction

endpackage

// File: rtl/mms_cmp_sel.sv
// Compare-and-select of a candidate operand against the running best, carrying indices along.
module mms_cmp_sel #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 2
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] best,
  input  logic [IDX_W-1:0] best_idx,
  input  logic [WIDTH-1:0] cand,
  input  logic [IDX_W-1:0] cand_idx,
  output logic [WIDTH-1:0] win,
  output logic [IDX_W-1:0] win_idx
);
  import mms_pkg::*;

  logic take;

  assign take    = better(mode, operand_t'(cand), operand_t'(best));
  assign win     = take ? cand : best;
  assign win_idx = take ? cand_idx : best_idx;

endmodule

// File: rtl/mms_stream.sv
// Serial max/min selector: folds one operand per cycle into a running best and
// presents the winner, its position and the frame length over a valid/ready port.
module mms_stream #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic [WIDTH-1:0] number,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W:0]   count
);
  import mms_pkg::*;

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(FRAME_LEN);
  localparam logic [IDX_W:0] ONE_CNT  = (IDX_W + 1)'(1);

  state_t           state, state_next;
  logic             mode;
  logic [WIDTH-1:0] best;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W:0]   cnt;
  logic [IDX_W:0]   cnt_inc;
  logic [WIDTH-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic             take_first, take_next, close_frame;

  assign cnt_inc = cnt + ONE_CNT;

  // cnt is always below FRAME_LEN while accumulating, so its low bits are the position.
  mms_cmp_sel #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_cmp_sel (
    .mode    (mode),
    .best    (best),
    .best_idx(best_idx),
    .cand    (number),
    .cand_idx(cnt[IDX_W-1:0]),
    .win     (win),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    take_first  = 1'b0;
    take_next   = 1'b0;
    close_frame = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          take_first = 1'b1;
          if (in_last) begin
            close_frame = 1'b1;
            state_next  = HOLD;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          take_next = 1'b1;
          if (in_last || (cnt_inc == LAST_CNT)) begin
            close_frame = 1'b1;
            state_next  = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);

  // Outputs are loaded only when the frame closes so they stay stable through HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode     <= MODE_MAX;
      best     <= '0;
      best_idx <= '0;
      cnt      <= '0;
      result   <= '0;
      index    <= '0;
      count    <= '0;
    end else begin
      if (take_first) begin
        mode     <= select;
        best     <= number;
        best_idx <= '0;
        cnt      <= ONE_CNT;
      end else if (take_next) begin
        best     <= win;
        best_idx <= win_idx;
        cnt      <= cnt_inc;
      end
      if (close_frame) begin
        result <= take_first ? number : win;
        index  <= take_first ? '0 : win_idx;
        count  <= take_first ? ONE_CNT : cnt_inc;
      end
    end
  end

endmodule
